// File: rtl/histogram_pkg.sv
// Shared types and default widths for the histogram controller.
// The state encoding is used by the top-level sequencer.
package histogram_pkg;

    localparam int unsigned DEF_PIX_W  = 8;
    localparam int unsigned DEF_ADDR_W = 9;
    localparam int unsigned DEF_CNT_W  = 32;

    localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StAccum,
        StDrain,
        StReadout
    } state_e;

endpackage

// File: rtl/histogram_rmw_pipe.sv
// Read-modify-write increment pipeline for histogram bins.
// S1 forwards from S2/S3 so back-to-back hits on one bin count exactly.
module histogram_rmw_pipe
    import histogram_pkg::*;
#(
    parameter int unsigned PIX_W = DEF_PIX_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             acc_vld_i,
    input  logic [PIX_W-1:0] acc_bin_i,
    input  logic [CNT_W-1:0] rd_data_i,
    output logic             wr_en_o,
    output logic [PIX_W-1:0] wr_bin_o,
    output logic [CNT_W-1:0] wr_data_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic             s1_vld_q, s1_vld_d;
    logic [PIX_W-1:0] s1_bin_q, s1_bin_d;
    logic             s2_vld_q, s2_vld_d;
    logic [PIX_W-1:0] s2_bin_q, s2_bin_d;
    logic [CNT_W-1:0] s2_sum_q, s2_sum_d;
    logic             s3_vld_q, s3_vld_d;
    logic [PIX_W-1:0] s3_bin_q, s3_bin_d;
    logic [CNT_W-1:0] s3_sum_q, s3_sum_d;
    logic [CNT_W-1:0] base;

    always_comb begin
        // S2 is being written this cycle; S3 was written while our read was in flight.
        if (s2_vld_q && (s2_bin_q == s1_bin_q)) begin
            base = s2_sum_q;
        end else if (s3_vld_q && (s3_bin_q == s1_bin_q)) begin
            base = s3_sum_q;
        end else begin
            base = rd_data_i;
        end

        s1_vld_d = acc_vld_i;
        s1_bin_d = acc_bin_i;
        s2_vld_d = s1_vld_q;
        s2_bin_d = s1_bin_q;
        s2_sum_d = (base == CntMax) ? base : base + CNT_W'(1);
        s3_vld_d = s2_vld_q;
        s3_bin_d = s2_bin_q;
        s3_sum_d = s2_sum_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_vld_q <= 1'b0;
            s1_bin_q <= '0;
            s2_vld_q <= 1'b0;
            s2_bin_q <= '0;
            s2_sum_q <= '0;
            s3_vld_q <= 1'b0;
            s3_bin_q <= '0;
            s3_sum_q <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_bin_q <= s1_bin_d;
            s2_vld_q <= s2_vld_d;
            s2_bin_q <= s2_bin_d;
            s2_sum_q <= s2_sum_d;
            s3_vld_q <= s3_vld_d;
            s3_bin_q <= s3_bin_d;
            s3_sum_q <= s3_sum_d;
        end
    end

    assign wr_en_o   = s2_vld_q;
    assign wr_bin_o  = s2_bin_q;
    assign wr_data_o = s2_sum_q;
    assign busy_o    = s1_vld_q | s2_vld_q | s3_vld_q;

endmodule

// File: rtl/histogram_ctrl.sv
// Frame sequencer for a dual-port histogram RAM: clear, accumulate, read out.
// Owns both RAM ports; port A writes, port B reads.
module histogram_ctrl
    import histogram_pkg::*;
#(
    parameter int unsigned PIX_W  = DEF_PIX_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              pix_vld,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_rdy,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [PIX_W-1:0]  out_bin,
    output logic [CNT_W-1:0]  out_cnt,
    output logic              out_last,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_a_addr,
    output logic [CNT_W-1:0]  ram_a_wr_data,
    output logic              ram_a_wr_en,
    output logic [ADDR_W-1:0] ram_b_addr,
    input  logic [CNT_W-1:0]  ram_b_rd_data
);

    localparam logic [PIX_W-1:0] LastBin = '1;

    state_e           state_q, state_d;
    logic [PIX_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [PIX_W-1:0] rd_idx_q, rd_idx_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_done_q, rd_done_d;
    logic             out_vld_q, out_vld_d;
    logic [PIX_W-1:0] out_bin_q, out_bin_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             out_last_q, out_last_d;
    logic             pix_rdy_q, pix_rdy_d;
    logic             busy_q, busy_d;

    logic             acc;
    logic             out_hs;
    logic             rd_issue;
    logic             pipe_busy;
    logic             wr_en;
    logic [PIX_W-1:0] wr_bin;
    logic [CNT_W-1:0] wr_sum;

    assign acc    = pix_vld & pix_rdy_q;
    assign out_hs = out_vld_q & out_rdy;

    histogram_rmw_pipe #(
        .PIX_W (PIX_W),
        .CNT_W (CNT_W)
    ) u_rmw_pipe (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .acc_vld_i (acc),
        .acc_bin_i (pix_data),
        .rd_data_i (ram_b_rd_data),
        .wr_en_o   (wr_en),
        .wr_bin_o  (wr_bin),
        .wr_data_o (wr_sum),
        .busy_o    (pipe_busy)
    );

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        rd_idx_d   = rd_idx_q;
        rd_pend_d  = rd_pend_q;
        rd_done_d  = rd_done_q;
        out_vld_d  = out_vld_q;
        out_bin_d  = out_bin_q;
        out_cnt_d  = out_cnt_q;
        out_last_d = out_last_q;
        rd_issue   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                end
            end
            StClear: begin
                clr_cnt_d = clr_cnt_q + PIX_W'(1);
                if (clr_cnt_q == LastBin) begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (frame_end) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!pipe_busy) begin
                    state_d   = StReadout;
                    rd_idx_d  = '0;
                    rd_pend_d = 1'b0;
                    rd_done_d = 1'b0;
                    out_vld_d = 1'b0;
                end
            end
            StReadout: begin
                // Next read is issued in the handshake cycle, giving two cycles per bin.
                rd_issue  = !rd_pend_q && !rd_done_q && (!out_vld_q || out_rdy);
                rd_pend_d = rd_issue;
                if (rd_issue) begin
                    rd_idx_d  = rd_idx_q + PIX_W'(1);
                    rd_done_d = (rd_idx_q == LastBin);
                end
                if (out_hs) begin
                    out_vld_d = 1'b0;
                end
                if (rd_pend_q) begin
                    out_vld_d  = 1'b1;
                    out_cnt_d  = ram_b_rd_data;
                    out_bin_d  = rd_idx_q - PIX_W'(1);
                    out_last_d = rd_done_q;
                end
                if (out_hs && out_last_q) begin
                    state_d    = StIdle;
                    out_vld_d  = 1'b0;
                    out_last_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        pix_rdy_d = (state_d == StAccum);
        busy_d    = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            clr_cnt_q  <= '0;
            rd_idx_q   <= '0;
            rd_pend_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            out_bin_q  <= '0;
            out_cnt_q  <= '0;
            out_last_q <= 1'b0;
            pix_rdy_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_idx_q   <= rd_idx_d;
            rd_pend_q  <= rd_pend_d;
            rd_done_q  <= rd_done_d;
            out_vld_q  <= out_vld_d;
            out_bin_q  <= out_bin_d;
            out_cnt_q  <= out_cnt_d;
            out_last_q <= out_last_d;
            pix_rdy_q  <= pix_rdy_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        if (state_q == StClear) begin
            ram_a_addr    = ADDR_W'(clr_cnt_q);
            ram_a_wr_data = '0;
            ram_a_wr_en   = 1'b1;
        end else begin
            ram_a_addr    = ADDR_W'(wr_bin);
            ram_a_wr_data = wr_sum;
            ram_a_wr_en   = wr_en;
        end

        if (state_q == StReadout) begin
            ram_b_addr = ADDR_W'(rd_idx_q);
        end else if (pix_rdy_q) begin
            ram_b_addr = ADDR_W'(pix_data);
        end else begin
            ram_b_addr = '0;
        end
    end

    assign pix_rdy  = pix_rdy_q;
    assign busy     = busy_q;
    assign out_vld  = out_vld_q;
    assign out_bin  = out_bin_q;
    assign out_cnt  = out_cnt_q;
    assign out_last = out_last_q;

endmodule

// File: tb/tb_histogram_ctrl.sv
// Directed bench for histogram_ctrl with a behavioural dual-port RAM and a
// readout scoreboard built from a reference histogram.
module tb_histogram_ctrl;
    import histogram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start, frame_end;
    logic        pix_vld;
    logic [7:0]  pix_data;
    logic        pix_rdy;
    logic        out_vld, out_rdy;
    logic [7:0]  out_bin;
    logic [31:0] out_cnt;
    logic        out_last;
    logic        busy;
    logic [8:0]  ram_a_addr, ram_b_addr;
    logic [31:0] ram_a_wr_data, ram_b_rd_data;
    logic        ram_a_wr_en;

    logic        fill;
    logic [31:0] mem [512];
    logic [31:0] model [256];
    int          n_pass  = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    histogram_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .frame_end     (frame_end),
        .pix_vld       (pix_vld),
        .pix_data      (pix_data),
        .pix_rdy       (pix_rdy),
        .out_vld       (out_vld),
        .out_rdy       (out_rdy),
        .out_bin       (out_bin),
        .out_cnt       (out_cnt),
        .out_last      (out_last),
        .busy          (busy),
        .ram_a_addr    (ram_a_addr),
        .ram_a_wr_data (ram_a_wr_data),
        .ram_a_wr_en   (ram_a_wr_en),
        .ram_b_addr    (ram_b_addr),
        .ram_b_rd_data (ram_b_rd_data)
    );

    // Read-before-write on a same-address collision, like a real TDP block RAM.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'hdead_0000 | 32'(i);
        end else if (ram_a_wr_en) begin
            mem[ram_a_addr] <= ram_a_wr_data;
        end
        ram_b_rd_data <= mem[ram_b_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start_frame();
        int errs = 0;
        for (int b = 0; b < 256; b++) model[b] = 32'd0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (ram_a_wr_en !== 1'b1 || ram_a_addr !== 9'(i) || ram_a_wr_data !== 32'd0 ||
                pix_rdy !== 1'b0 || busy !== 1'b1) errs++;
            step();
        end
        check("clear_sweep", 64'(errs), 64'd0);
        check("clear_end_wr_en", 64'(ram_a_wr_en), 64'd0);
        check("accum_pix_rdy", 64'(pix_rdy), 64'd1);
    endtask

    task automatic send_pix(input logic [7:0] v, input bit last);
        pix_vld   = 1'b1;
        pix_data  = v;
        frame_end = last;
        model[v]  = (model[v] == CNT_MAX) ? model[v] : model[v] + 32'd1;
        step();
        pix_vld   = 1'b0;
        frame_end = 1'b0;
        if (last) check("drain_pix_rdy", 64'(pix_rdy), 64'd0);
    endtask

    task automatic run_readout(input bit rand_rdy);
        logic [40:0] exp_q [$];
        logic [40:0] cur, prev_val;
        bit          prev_stall = 1'b0;
        int          hs = 0, cyc = 0, stall_err = 0;
        prev_val = '0;
        for (int b = 0; b < 256; b++) exp_q.push_back({(b == 255), 8'(b), model[b]});
        while (hs < 256 && cyc < 4000) begin
            cur = {out_last, out_bin, out_cnt};
            if (prev_stall && (out_vld !== 1'b1 || cur !== prev_val)) stall_err++;
            out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_vld && out_rdy) begin
                check($sformatf("readout_bin%0d", hs), 64'(cur), 64'(exp_q.pop_front()));
                hs++;
            end
            prev_stall = out_vld && !out_rdy;
            prev_val   = cur;
            step();
            cyc++;
        end
        out_rdy = 1'b0;
        check("readout_handshakes", 64'(hs), 64'd256);
        check("readout_stall_stable", 64'(stall_err), 64'd0);
        check("busy_after_readout", 64'(busy), 64'd0);
        check("out_vld_after_readout", 64'(out_vld), 64'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        fill        = 1'b1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        pix_vld     = 1'b0;
        pix_data    = 8'd0;
        out_rdy     = 1'b0;
        step();
        fill = 1'b0;
        step();

        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pix_rdy", 64'(pix_rdy), 64'd0);
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_cnt", 64'(out_cnt), 64'd0);
        check("rst_out_bin", 64'(out_bin), 64'd0);
        check("rst_wr_en", 64'(ram_a_wr_en), 64'd0);
        check("rst_a_addr", 64'(ram_a_addr), 64'd0);
        check("rst_a_data", 64'(ram_a_wr_data), 64'd0);
        check("rst_b_addr", 64'(ram_b_addr), 64'd0);
        rst_n = 1'b1;
        step();

        // frame_end in IDLE must not start anything.
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        step();
        check("idle_frame_end_ignored", 64'(busy), 64'd0);

        // Frame 1: pixels 0..9, frame_end coincides with the last accepted pixel.
        start_frame();
        for (int i = 0; i < 10; i++) send_pix(8'(i), i == 9);
        run_readout(1'b0);

        // Frame 2: 1000 back-to-back hits on one bin; frame_start mid-stream is ignored.
        start_frame();
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) frame_start = 1'b1;
            send_pix(8'h55, i == 999);
            frame_start = 1'b0;
        end
        run_readout(1'b0);

        // Frame 3: alternating bins exercise the one-cycle-old write forwarding.
        start_frame();
        for (int i = 0; i < 64; i++) send_pix((i % 2 == 0) ? 8'd3 : 8'd200, i == 63);
        run_readout(1'b1);

        // Frame 4: abort mid-accumulation, then a fresh frame.
        start_frame();
        for (int i = 0; i < 20; i++) send_pix(8'd9, 1'b0);
        pix_vld = 1'b1;
        pix_data = 8'd9;
        rst_n = 1'b0;
        step();
        pix_vld = 1'b0;
        rst_n = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_pix_rdy", 64'(pix_rdy), 64'd0);
        check("abort_out_vld", 64'(out_vld), 64'd0);
        step();
        step();
        step();
        check("abort_no_write", 64'(ram_a_wr_en), 64'd0);
        start_frame();
        for (int i = 0; i < 5; i++) send_pix(8'd7, i == 4);
        run_readout(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
